// File: rtl/dp_mem_port_queue.sv
// Per-port command/response queue in front of one DP_MEM port; reads are credit-limited.
// Define DP_MEM_QUEUE_STATS_EN to build the saturating write/read/full statistics counters.
module dp_mem_port_queue #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_op,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wr_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_full
);

  localparam int CMD_PW = $clog2(CMD_DEPTH);
  localparam int CMD_CW = CMD_PW + 1;
  localparam int RSP_PW = $clog2(RSP_DEPTH);
  localparam int RSP_CW = RSP_PW + 1;
  localparam logic [CMD_CW-1:0] CMD_FULL = CMD_CW'(CMD_DEPTH);
  localparam logic [RSP_CW-1:0] RSP_FULL = RSP_CW'(RSP_DEPTH);

  logic              cmd_op_q   [CMD_DEPTH];
  logic              cmd_op_d   [CMD_DEPTH];
  logic [ADDR_W-1:0] cmd_addr_q [CMD_DEPTH];
  logic [ADDR_W-1:0] cmd_addr_d [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_data_q [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_data_d [CMD_DEPTH];
  logic [CMD_PW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d;
  logic [CMD_PW-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [CMD_CW-1:0] cmd_count_q, cmd_count_d;

  logic [ADDR_W-1:0] rsp_addr_q [RSP_DEPTH];
  logic [ADDR_W-1:0] rsp_addr_d [RSP_DEPTH];
  logic [DATA_W-1:0] rsp_data_q [RSP_DEPTH];
  logic [DATA_W-1:0] rsp_data_d [RSP_DEPTH];
  logic [RSP_PW-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d;
  logic [RSP_PW-1:0] rsp_rd_ptr_q, rsp_rd_ptr_d;
  logic [RSP_CW-1:0] rsp_count_q, rsp_count_d;

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;

  logic              head_op;
  logic [RSP_CW:0]   credit_used;
  logic              credit_ok;
  logic              cmd_push, cmd_pop, rd_xfer, rsp_push, rsp_pop;

  // A read may only issue if its response is guaranteed a slot, counting the one in flight.
  always_comb begin
    head_op     = cmd_op_q[cmd_rd_ptr_q];
    credit_used = {1'b0, rsp_count_q} + {{RSP_CW{1'b0}}, inflight_q};
    credit_ok   = credit_used < {1'b0, RSP_FULL};
    s_ready     = !rst && (cmd_count_q < CMD_FULL);
    mem_valid   = !rst && (cmd_count_q != '0) && (head_op || credit_ok);
    mem_op      = mem_valid ? head_op : 1'b0;
    mem_addr    = mem_valid ? cmd_addr_q[cmd_rd_ptr_q] : '0;
    mem_wr_data = mem_valid ? cmd_data_q[cmd_rd_ptr_q] : '0;
    cmd_push    = s_valid && s_ready;
    cmd_pop     = mem_valid && mem_ready;
    rd_xfer     = cmd_pop && !head_op;
    rsp_push    = inflight_q;
    r_valid     = rsp_count_q != '0;
    r_addr      = r_valid ? rsp_addr_q[rsp_rd_ptr_q] : '0;
    r_data      = r_valid ? rsp_data_q[rsp_rd_ptr_q] : '0;
    rsp_pop     = r_valid && r_ready;
  end

  always_comb begin
    cmd_wr_ptr_d    = cmd_wr_ptr_q;
    cmd_rd_ptr_d    = cmd_rd_ptr_q;
    cmd_count_d     = cmd_count_q;
    rsp_wr_ptr_d    = rsp_wr_ptr_q;
    rsp_rd_ptr_d    = rsp_rd_ptr_q;
    rsp_count_d     = rsp_count_q;
    inflight_d      = rd_xfer;
    inflight_addr_d = rd_xfer ? cmd_addr_q[cmd_rd_ptr_q] : inflight_addr_q;
    if (cmd_push) cmd_wr_ptr_d = cmd_wr_ptr_q + 1'b1;
    if (cmd_pop) cmd_rd_ptr_d = cmd_rd_ptr_q + 1'b1;
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_count_d = cmd_count_q + 1'b1;
      2'b01:   cmd_count_d = cmd_count_q - 1'b1;
      default: cmd_count_d = cmd_count_q;
    endcase
    if (rsp_push) rsp_wr_ptr_d = rsp_wr_ptr_q + 1'b1;
    if (rsp_pop) rsp_rd_ptr_d = rsp_rd_ptr_q + 1'b1;
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_count_d = rsp_count_q + 1'b1;
      2'b01:   rsp_count_d = rsp_count_q - 1'b1;
      default: rsp_count_d = rsp_count_q;
    endcase
  end

  always_comb begin
    cmd_op_d   = cmd_op_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    if (cmd_push) begin
      cmd_op_d[cmd_wr_ptr_q]   = s_op;
      cmd_addr_d[cmd_wr_ptr_q] = s_addr;
      cmd_data_d[cmd_wr_ptr_q] = s_wr_data;
    end
    if (rsp_push) begin
      rsp_addr_d[rsp_wr_ptr_q] = inflight_addr_q;
      rsp_data_d[rsp_wr_ptr_q] = mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_ptr_q    <= '0;
      cmd_rd_ptr_q    <= '0;
      cmd_count_q     <= '0;
      rsp_wr_ptr_q    <= '0;
      rsp_rd_ptr_q    <= '0;
      rsp_count_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      cmd_wr_ptr_q    <= cmd_wr_ptr_d;
      cmd_rd_ptr_q    <= cmd_rd_ptr_d;
      cmd_count_q     <= cmd_count_d;
      rsp_wr_ptr_q    <= rsp_wr_ptr_d;
      rsp_rd_ptr_q    <= rsp_rd_ptr_d;
      rsp_count_q     <= rsp_count_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  // Entry storage needs no reset: the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    cmd_op_q   <= cmd_op_d;
    cmd_addr_q <= cmd_addr_d;
    cmd_data_q <= cmd_data_d;
    rsp_addr_q <= rsp_addr_d;
    rsp_data_q <= rsp_data_d;
  end

`ifdef DP_MEM_QUEUE_STATS_EN
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_full_q, stat_full_d;

  always_comb begin
    stat_wr_d   = stat_wr_q;
    stat_rd_d   = stat_rd_q;
    stat_full_d = stat_full_q;
    if (cmd_pop && head_op && (stat_wr_q != '1)) stat_wr_d = stat_wr_q + 32'd1;
    if (rd_xfer && (stat_rd_q != '1)) stat_rd_d = stat_rd_q + 32'd1;
    if ((cmd_count_q == CMD_FULL) && (stat_full_q != '1)) stat_full_d = stat_full_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_q   <= '0;
      stat_rd_q   <= '0;
      stat_full_q <= '0;
    end else begin
      stat_wr_q   <= stat_wr_d;
      stat_rd_q   <= stat_rd_d;
      stat_full_q <= stat_full_d;
    end
  end

  assign stat_wr   = stat_wr_q;
  assign stat_rd   = stat_rd_q;
  assign stat_full = stat_full_q;
`else
  assign stat_wr   = '0;
  assign stat_rd   = '0;
  assign stat_full = '0;
`endif

endmodule

// File: tb/tb_dp_mem_port_queue.sv
// Randomized and directed bench for dp_mem_port_queue against a program-order queue model.
// Honors DP_MEM_QUEUE_STATS_EN for the expected statistics values.
module tb_dp_mem_port_queue;

  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
`ifdef DP_MEM_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_ready, s_op = 1'b0;
  logic [7:0]  s_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic        mem_valid, mem_ready = 1'b0, mem_op;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data = '0;
  logic        r_valid, r_ready = 1'b0;
  logic [7:0]  r_addr;
  logic [31:0] r_data;
  logic [31:0] stat_wr, stat_rd, stat_full;

  dp_mem_port_queue #(.ADDR_W(8), .DATA_W(32), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr), .r_data(r_data),
    .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_full(stat_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic op; logic [7:0] addr; logic [31:0] data;} cmd_t;
  typedef struct packed {logic [7:0] addr; logic [31:0] data;} rsp_t;

  cmd_t        cmdq[$];
  rsp_t        rspq[$];
  logic [31:0] ref_mem [256];
  logic [31:0] env_mem [256];
  int          avail, wr_cnt, rd_cnt, full_cnt, obs_rd, obs_rsp;
  bit          inflight_m, last_s_fire;
  logic [7:0]  inflight_addr;
  int          total, bad;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock: drive at negedge, check against the model, then advance the model at posedge.
  task automatic applyStimulus(input logic i_rst, input logic i_valid, input logic i_op,
                               input logic [7:0] i_addr, input logic [31:0] i_data,
                               input logic i_mrdy, input logic i_rrdy);
    bit exp_s_ready, exp_mem_valid, exp_r_valid, s_fire, m_fire, r_fire;
    logic m_op;
    logic [7:0] m_addr;
    logic [31:0] m_data;
    cmd_t nc;
    @(negedge clk);
    rst = i_rst; s_valid = i_valid; s_op = i_op; s_addr = i_addr; s_wr_data = i_data;
    mem_ready = i_mrdy; r_ready = i_rrdy;
    mem_rd_data = inflight_m ? env_mem[inflight_addr] : $urandom();
    #1;
    exp_s_ready = !i_rst && (cmdq.size() < CMD_DEPTH);
    exp_mem_valid = 1'b0;
    if (!i_rst && cmdq.size() > 0)
      exp_mem_valid = cmdq[0].op || ((avail + int'(inflight_m)) < RSP_DEPTH);
    exp_r_valid = avail > 0;
    checkOutput("s_ready", s_ready, exp_s_ready);
    checkOutput("mem_valid", mem_valid, exp_mem_valid);
    if (exp_mem_valid) begin
      checkOutput("mem_op", mem_op, cmdq[0].op);
      checkOutput("mem_addr", mem_addr, cmdq[0].addr);
      if (cmdq[0].op) checkOutput("mem_wr_data", mem_wr_data, cmdq[0].data);
    end
    if (!i_rst) begin
      checkOutput("r_valid", r_valid, exp_r_valid);
      if (exp_r_valid) begin
        checkOutput("r_addr", r_addr, rspq[0].addr);
        checkOutput("r_data", r_data, rspq[0].data);
      end
      if (r_valid && i_rrdy) obs_rsp++;
    end
    if (mem_valid && i_mrdy && !mem_op) obs_rd++;
    s_fire = i_valid && exp_s_ready;
    m_fire = exp_mem_valid && i_mrdy;
    r_fire = exp_r_valid && i_rrdy && !i_rst;
    m_op = mem_op; m_addr = mem_addr; m_data = mem_wr_data;
    @(posedge clk);
    last_s_fire = s_fire;
    if (i_rst) begin
      cmdq.delete(); rspq.delete();
      avail = 0; inflight_m = 1'b0; wr_cnt = 0; rd_cnt = 0; full_cnt = 0;
      ref_mem = env_mem;
    end else begin
      if (cmdq.size() == CMD_DEPTH) full_cnt++;
      if (r_fire) begin
        void'(rspq.pop_front());
        avail--;
      end
      if (inflight_m) avail++;
      inflight_m = 1'b0;
      if (m_fire) begin
        nc = cmdq.pop_front();
        if (nc.op) begin
          wr_cnt++;
          if (m_op) env_mem[m_addr] = m_data;
        end else begin
          rd_cnt++;
          inflight_m = 1'b1;
          inflight_addr = m_addr;
        end
      end
      if (s_fire) begin
        if (i_op) ref_mem[i_addr] = i_data;
        else rspq.push_back('{i_addr, ref_mem[i_addr]});
        cmdq.push_back('{i_op, i_addr, i_data});
      end
    end
  endtask

  task automatic sendCmd(input logic op, input logic [7:0] addr, input logic [31:0] data,
                         input logic mrdy, input logic rrdy);
    int n = 0;
    last_s_fire = 1'b0;
    while (!last_s_fire && n < 50) begin
      applyStimulus(1'b0, 1'b1, op, addr, data, mrdy, rrdy);
      n++;
    end
    if (!last_s_fire) checkOutput("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input logic mrdy, input logic rrdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, mrdy, rrdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
  endtask

  initial begin
    int base_rd, base_rsp;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end

    // Reset values
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
    doReset();
    #2;
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_mem_valid", mem_valid, 0);
    checkOutput("rst_r_valid", r_valid, 0);
    checkOutput("rst_mem_op", mem_op, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wr_data", mem_wr_data, 0);
    checkOutput("rst_r_addr", r_addr, 0);
    checkOutput("rst_r_data", r_data, 0);
    checkOutput("rst_stats", {stat_wr, stat_rd ^ stat_full}, 0);

    // Write then read back, one-cycle issue latency
    base_rsp = obs_rsp;
    sendCmd(1'b1, 8'h10, 32'hDEADBEEF, 1'b1, 1'b1);
    #2;
    checkOutput("s1_latency_valid", mem_valid, 1);
    checkOutput("s1_latency_addr", mem_addr, 8'h10);
    sendCmd(1'b0, 8'h10, 32'h0, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);
    checkOutput("s1_rsp_count", obs_rsp - base_rsp, 1);

    // Command FIFO full with the memory port stalled
    sendCmd(1'b1, 8'h30, 32'h11, 1'b0, 1'b1);
    sendCmd(1'b0, 8'h30, 32'h0, 1'b0, 1'b1);
    sendCmd(1'b1, 8'h31, 32'h22, 1'b0, 1'b1);
    sendCmd(1'b0, 8'h31, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h32, 32'h33, 1'b0, 1'b1);
    #2;
    checkOutput("s2_full_s_ready", s_ready, 0);
    checkOutput("s2_held_addr", mem_addr, 8'h30);
    sendCmd(1'b1, 8'h32, 32'h33, 1'b1, 1'b1);
    idle(8, 1'b1, 1'b1);

    // Response credit limit
    base_rd = obs_rd;
    for (int i = 0; i < 6; i++) sendCmd(1'b0, 8'h30 + 8'(i), 32'h0, 1'b1, 1'b0);
    idle(4, 1'b1, 1'b0);
    #2;
    checkOutput("s3_reads_issued", obs_rd - base_rd, 4);
    checkOutput("s3_blocked", mem_valid, 0);
    idle(1, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b0);
    checkOutput("s3_one_more", obs_rd - base_rd, 5);
    idle(12, 1'b1, 1'b1);

    // Interleaved writes and reads to one address
    base_rsp = obs_rsp;
    sendCmd(1'b1, 8'h20, 32'h1, 1'b1, 1'b1);
    sendCmd(1'b0, 8'h20, 32'h0, 1'b1, 1'b1);
    sendCmd(1'b1, 8'h20, 32'h2, 1'b1, 1'b1);
    sendCmd(1'b0, 8'h20, 32'h0, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);
    checkOutput("s4_rsp_count", obs_rsp - base_rsp, 2);

    // Reset one cycle after a read transfer, three commands still queued
    sendCmd(1'b0, 8'h40, 32'h0, 1'b0, 1'b1);
    sendCmd(1'b0, 8'h41, 32'h0, 1'b0, 1'b1);
    sendCmd(1'b1, 8'h42, 32'h5, 1'b0, 1'b1);
    sendCmd(1'b1, 8'h43, 32'h6, 1'b0, 1'b1);
    idle(1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b1);
    idle(1, 1'b1, 1'b1);
    #2;
    checkOutput("s5_r_valid", r_valid, 0);
    checkOutput("s5_mem_valid", mem_valid, 0);
    checkOutput("s5_s_ready", s_ready, 1);
    idle(4, 1'b1, 1'b1);

    // Statistics: 3 writes, 2 reads, 7 cycles full
    doReset();
    sendCmd(1'b1, 8'h60, 32'h1, 1'b0, 1'b1);
    sendCmd(1'b1, 8'h61, 32'h2, 1'b0, 1'b1);
    sendCmd(1'b1, 8'h62, 32'h3, 1'b0, 1'b1);
    sendCmd(1'b0, 8'h60, 32'h0, 1'b0, 1'b1);
    idle(6, 1'b0, 1'b1);
    idle(1, 1'b1, 1'b1);
    sendCmd(1'b0, 8'h61, 32'h0, 1'b1, 1'b1);
    idle(8, 1'b1, 1'b1);
    #2;
    checkOutput("s6_stat_wr", stat_wr, STATS ? 32'd3 : 32'd0);
    checkOutput("s6_stat_rd", stat_rd, STATS ? 32'd2 : 32'd0);
    checkOutput("s6_stat_full", stat_full, STATS ? 32'd7 : 32'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0), $urandom_range(0, 99) < 70, 1'($urandom()),
                    {4'h5, 4'($urandom())}, $urandom(),
                    $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60);
    end
    idle(20, 1'b1, 1'b1);
    #2;
    checkOutput("rand_stat_wr", stat_wr, STATS ? wr_cnt : 0);
    checkOutput("rand_stat_rd", stat_rd, STATS ? rd_cnt : 0);
    checkOutput("rand_stat_full", stat_full, STATS ? full_cnt : 0);
    checkOutput("rand_drained", r_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_mem_port_queue.md
# dp_mem_port_queue

Per-port request queue placed directly upstream of one port of the dual-port memory (`DP_MEM`); one instance per port. Buffers client read/write commands, issues them in order to the memory port over its valid/ready handshake, and captures read data into a response FIFO with its own valid/ready. Read issue is credit-limited, so returned read data is never dropped under response backpressure.

## Interface
- `ADDR_W`, 8, address width
- `DATA_W`, 32, data width
- `CMD_DEPTH`, 4, command FIFO entries (power of 2, ≥2)
- `RSP_DEPTH`, 4, response FIFO entries (power of 2, ≥2)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  client command valid
- `s_ready`  out  1  queue can accept a command
- `s_op`  in  1  1 = write, 0 = read
- `s_addr`  in  ADDR_W  command address
- `s_wr_data`  in  DATA_W  write data (ignored for reads)
- `mem_valid`  out  1  command presented to memory port
- `mem_ready`  in  1  memory port accepts command
- `mem_op`  out  1  to memory `op`
- `mem_addr`  out  ADDR_W  to memory `addr`
- `mem_wr_data`  out  DATA_W  to memory `wr_data`
- `mem_rd_data`  in  DATA_W  memory read data, valid the cycle after a read transfer
- `r_valid`  out  1  response available
- `r_ready`  in  1  client takes response
- `r_addr`  out  ADDR_W  address of the read
- `r_data`  out  DATA_W  read data
- `stat_wr`, `stat_rd`, `stat_full`  out  32 each  statistics counters (see Configuration)

## Operation
- Transfer on any channel occurs when valid && ready at a rising edge.
- Command FIFO: accepts `{op, addr, wr_data}`; `s_ready` = !rst && cmd_count < CMD_DEPTH, derived from registered count only. Push into a full FIFO is never allowed, even when a pop happens in the same cycle.
- Head issue: `mem_valid` = cmd not empty && (head is write || credit available). Credit available: rsp_count + inflight < RSP_DEPTH. `mem_op/addr/wr_data` reflect the head while `mem_valid` is high and hold stable until transfer.
- Read transfer sets `inflight` (1 bit) with the head address. Next cycle, `mem_rd_data` + latched address are pushed into the response FIFO and `inflight` clears unless another read transfers in that cycle.
- Write transfer: pop only; no response.
- Strict program order; no reordering or forwarding.
- Response FIFO: `r_valid` = rsp not empty; head drives `r_addr/r_data`; popped on `r_valid && r_ready`. Simultaneous push and pop keeps the count unchanged. Overflow cannot occur because of the credit rule.
- Counts are modulo-free: cmd_count ∈ [0, CMD_DEPTH], rsp_count ∈ [0, RSP_DEPTH]. Pointers wrap at depth.

## Timing
- Reset values: `s_ready`=0 while `rst`=1, then 1 the first cycle after release. `mem_valid`=0, `r_valid`=0, `mem_*` data=0, `r_*` data=0, stats=0, `inflight`=0.
- Latency: a command accepted at edge N appears on `mem_*` at cycle N+1 if the FIFO was empty. A read transferring at edge M has its data sampled at edge M+1, and `r_valid` is high in cycle M+1 (after that edge).
- Throughput: one command per cycle on each side when unblocked; back-to-back reads sustain 1/cycle while RSP_DEPTH credits allow.
- Reset mid-operation: all queued commands and responses are discarded, `inflight` clears, and `mem_rd_data` in the cycle after reset is ignored.

## Configuration
- `DP_MEM_QUEUE_STATS_EN` defined: `stat_wr` increments per write transfer to memory, `stat_rd` per read transfer, and `stat_full` per cycle with cmd_count == CMD_DEPTH. Counters saturate at 2^32-1 and clear on `rst`.
- Not defined: counters are not built; the three outputs are tied to 0.

## Test plan
- After reset, write addr 0x10 data 0xDEADBEEF, then read 0x10, with `mem_ready`=1 and the model returning stored data -> `mem_valid` at N+1; one response with `r_addr`=0x10, `r_data`=0xDEADBEEF; no response for the write.
- `mem_ready`=0, push 5 commands with CMD_DEPTH=4 -> 4 accepted, `s_ready`=0 from the 4th, `mem_*` held stable; release `mem_ready` -> issued in order 1..4, then the 5th is accepted.
- `r_ready`=0, 6 reads queued with RSP_DEPTH=4 -> exactly 4 read transfers, then `mem_valid`=0 with a read at head; pulse `r_ready` once -> exactly one more read issued.
- Interleave write 0x20←0x1, read 0x20, write 0x20←0x2, read 0x20 -> responses 0x1 then 0x2 in order.
- Assert `rst` one cycle after a read transfer with 3 commands queued -> no `r_valid`, `mem_valid`=0, and `s_ready` returns 1 the cycle after release.
- With `DP_MEM_QUEUE_STATS_EN`: 3 writes, 2 reads, and 7 cycles held full -> `stat_wr`=3, `stat_rd`=2, `stat_full`=7. Without the macro, all three read 0.
